// File: rtl/sync2_tgen.sv
// Toggle-handshake request source: one req becomes one tgl inversion, held busy until the 2-flop-synced ack toggle matches.
// Latency: tgl inverts on the req edge; busy falls two edges after a1 first samples the ack edge.
// Backpressure: a req while busy is queued in pend (SYNC2_TGEN_QUEUE_EN) or dropped with a drop pulse.
module sync2_tgen #(
    parameter int PEND_W = 4
) (
    input  logic              c,
    input  logic              rst_n,
    input  logic              req,
    input  logic              ack_tgl,
    output logic              tgl,
    output logic              busy,
    output logic              drop,
    output logic [PEND_W-1:0] pend
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state;
    logic   a1;
    logic   a2;

`ifdef SYNC2_TGEN_QUEUE_EN
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
`endif

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            a1    <= 1'b0;
            a2    <= 1'b0;
            tgl   <= 1'b0;
            busy  <= 1'b0;
            drop  <= 1'b0;
            pend  <= '0;
            state <= S_IDLE;
        end else begin
            a1   <= ack_tgl;
            a2   <= a1;
            drop <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A fresh req rides on this issue and stands in for the queued one it would otherwise consume.
                    if (req || (pend != '0)) begin
                        tgl   <= ~tgl;
                        busy  <= 1'b1;
                        state <= S_WAIT;
                        if (!req) begin
                            pend <= pend - 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (a2 == tgl) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    // The completion edge still counts as WAIT, so a req here is queued or dropped.
                    if (req) begin
`ifdef SYNC2_TGEN_QUEUE_EN
                        if (pend == PEND_MAX) begin
                            drop <= 1'b1;
                        end else begin
                            pend <= pend + 1'b1;
                        end
`else
                        drop <= 1'b1;
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync2_tgen.sv
// Directed vector bench for sync2_tgen (PEND_W=2); the destination ack toggle is driven by hand.
module tb_sync2_tgen;

    logic       c;
    logic       rst_n;
    logic       req;
    logic       ack_tgl;
    logic       tgl;
    logic       busy;
    logic       drop;
    logic [1:0] pend;

    int n_chk;
    int n_fail;

    typedef struct {
        logic       req;
        logic       ack;
        logic       tgl;
        logic       busy;
        logic       drop;
        logic [1:0] pend;
    } vec_t;

    vec_t tbl[$];

    sync2_tgen #(.PEND_W(2)) dut (
        .c       (c),
        .rst_n   (rst_n),
        .req     (req),
        .ack_tgl (ack_tgl),
        .tgl     (tgl),
        .busy    (busy),
        .drop    (drop),
        .pend    (pend)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rq, input logic ak, input logic et, input logic eb,
                       input logic ed, input logic [1:0] ep);
        vec_t v;
        v.req = rq; v.ack = ak; v.tgl = et; v.busy = eb; v.drop = ed; v.pend = ep;
        tbl.push_back(v);
    endtask

    task automatic step;
        @(posedge c);
        #1;
    endtask

    task automatic chk_all(input string name, input logic et, input logic eb,
                           input logic ed, input logic [1:0] ep);
        chk({name, ".tgl"}, 8'(tgl), 8'(et));
        chk({name, ".busy"}, 8'(busy), 8'(eb));
        chk({name, ".drop"}, 8'(drop), 8'(ed));
        chk({name, ".pend"}, 8'(pend), 8'(ep));
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        req     = 1'b0;
        ack_tgl = 1'b0;

        // req, ack, tgl, busy, drop, pend (outputs after the edge)
        // single transfer: ack captured by a1 at edge 1, busy falls after edge 3
        add(1, 0, 1, 1, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        add(0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0);
`ifdef SYNC2_TGEN_QUEUE_EN
        // three reqs in WAIT queue up, then drain one per ack
        add(1, 1, 0, 1, 0, 0);
        add(1, 1, 0, 1, 0, 1);
        add(1, 1, 0, 1, 0, 2);
        add(1, 1, 0, 1, 0, 3);
        add(0, 0, 0, 1, 0, 3);
        add(0, 0, 0, 1, 0, 3);
        add(0, 0, 0, 0, 0, 3);
        add(0, 0, 1, 1, 0, 2);
        add(0, 1, 1, 1, 0, 2);
        add(0, 1, 1, 1, 0, 2);
        add(0, 1, 1, 0, 0, 2);
        add(0, 1, 0, 1, 0, 1);
        add(0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 1, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        add(0, 1, 1, 0, 0, 0);
        // req on the completion edge queues, then req + pend in IDLE keeps pend
        add(1, 1, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 1);
        add(1, 0, 1, 1, 0, 1);
        add(0, 1, 1, 1, 0, 1);
        add(0, 1, 1, 1, 0, 1);
        add(0, 1, 1, 0, 0, 1);
        add(0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        // saturation: five reqs in WAIT, pend stops at 3, two drops
        add(1, 0, 1, 1, 0, 0);
        add(1, 0, 1, 1, 0, 1);
        add(1, 0, 1, 1, 0, 2);
        add(1, 0, 1, 1, 0, 3);
        add(1, 0, 1, 1, 1, 3);
        add(0, 0, 1, 1, 0, 3);
        add(1, 0, 1, 1, 1, 3);
        add(0, 0, 1, 1, 0, 3);
`else
        // reqs in WAIT are lost; completion-edge req also counts as WAIT
        add(1, 1, 0, 1, 0, 0);
        add(1, 1, 0, 1, 1, 0);
        add(0, 1, 0, 1, 0, 0);
        add(1, 1, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        add(0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0);
`endif

        // reset state
        step();
        step();
        chk_all("reset", 0, 0, 0, 0);
        @(negedge c);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            req     = tbl[i].req;
            ack_tgl = tbl[i].ack;
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].tgl, tbl[i].busy, tbl[i].drop, tbl[i].pend);
        end

        // reset mid-WAIT discards the transfer and any queue
        req     = 1'b0;
        ack_tgl = 1'b0;
        rst_n   = 1'b0;
        step();
        @(negedge c);
        rst_n = 1'b1;
        req   = 1'b1;
        step();
        chk_all("mid.issue", 1, 1, 0, 0);
`ifdef SYNC2_TGEN_QUEUE_EN
        step();
        step();
        req = 1'b0;
        chk_all("mid.pend2", 1, 1, 0, 2);
`else
        step();
        req = 1'b0;
        chk_all("mid.drop", 1, 1, 1, 0);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("mid.rst", 0, 0, 0, 0);
        step();
        @(negedge c);
        rst_n = 1'b1;
        req   = 1'b1;
        step();
        req = 1'b0;
        chk_all("post.rst", 1, 1, 0, 0);
        step();
        chk_all("post.hold", 1, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
